// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transaction arbiter.
// Holds the arbiter state encoding, the read/write direction constants
// used on req_rw, and the default timeout and inter-transaction gap lengths.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        RUN,
        RESP,
        GAP_WAIT
    } arb_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int DEFAULT_GAP     = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Finds the first set bit of req, starting at position ptr and wrapping
// modulo N, so the requester at ptr has the highest priority this round.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the highest-priority requester
//   idx   - index of the selected requester (0 when nothing is found)
//   found - high when at least one req bit is set
module rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    // Walk the requesters in priority order starting at ptr; the first
    // pending one wins and later candidates are ignored once found is set.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found) begin
                cand = IW'((int'(ptr) + k) % N);
                if (req[cand]) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master engine between N_REQ register clients.
// A round-robin pick chooses one pending requester; its direction, device,
// register address and write data are latched and driven to the engine
// together with the send or receive enable. The engine is given TIMEOUT
// cycles to pulse eng_done; the outcome (read byte or timeout) is returned
// as a one-cycle rsp_valid pulse to the winner, and both enables are then
// held low for GAP cycles so the engine can reset itself.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   req_valid/rw      - per-requester pending flag and direction (1 = read)
//   req_dev/addr/wdata- packed per-requester device, register and data
//   rsp_valid         - one-hot completion pulse to the owning requester
//   rsp_rdata/rsp_err - read byte and timeout flag, valid with rsp_valid
//   busy              - high from grant until the end of the gap
//   eng_send_en/recv_en, eng_dev/addr/wdata - engine control and operands
//   eng_done/eng_rdata- engine completion pulse and read byte
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int GAP     = DEFAULT_GAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_dev,
    input  logic [8*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               eng_send_en,
    output logic               eng_recv_en,
    output logic [6:0]         eng_dev,
    output logic [7:0]         eng_addr,
    output logic [7:0]         eng_wdata,
    input  logic               eng_done,
    input  logic [7:0]         eng_rdata
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          lat_rw;
    logic [CW-1:0] cnt;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

    rr_pick #(
        .N(N_REQ)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Arbiter FSM. The engine operands and enables are loaded on the
    // IDLE->GRANT edge so the enable is already high during GRANT, and those
    // registers double as the latched copy of the request: later changes on
    // req_* cannot reach the engine. The same counter times the engine in
    // RUN and the quiet gap in GAP_WAIT. eng_done is only looked at in RUN,
    // and it is tested before the timeout so a coincident completion wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            winner      <= '0;
            lat_rw      <= RW_WRITE;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= 8'h00;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            eng_send_en <= 1'b0;
            eng_recv_en <= 1'b0;
            eng_dev     <= 7'h00;
            eng_addr    <= 8'h00;
            eng_wdata   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        winner      <= pick_idx;
                        lat_rw      <= req_rw[pick_idx];
                        eng_dev     <= req_dev[int'(pick_idx)*7 +: 7];
                        eng_addr    <= req_addr[int'(pick_idx)*8 +: 8];
                        eng_wdata   <= req_wdata[int'(pick_idx)*8 +: 8];
                        eng_send_en <= (req_rw[pick_idx] == RW_WRITE);
                        eng_recv_en <= (req_rw[pick_idx] == RW_READ);
                        busy        <= 1'b1;
                        cnt         <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (eng_done) begin
                        rsp_rdata   <= (lat_rw == RW_READ) ? eng_rdata : 8'h00;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= N_REQ'(1) << winner;
                        eng_send_en <= 1'b0;
                        eng_recv_en <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_rdata   <= 8'h00;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= N_REQ'(1) << winner;
                        eng_send_en <= 1'b0;
                        eng_recv_en <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_rdata <= 8'h00;
                    rsp_err   <= 1'b0;
                    if (int'(winner) == N_REQ - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= winner + 1'b1;
                    end
                    cnt   <= '0;
                    state <= GAP_WAIT;
                end
                GAP_WAIT: begin
                    if (cnt == CW'(GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter with two requesters, a shortened timeout
// and a four-cycle gap. A small engine model pulses eng_done a chosen
// number of RUN cycles after grant (or never). Transactions come from a
// table of requests with hand-computed outcomes; reset mid-transaction and
// round-robin fairness are driven as separate sequences.
module tb_i2c_txn_arbiter;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 320;
    localparam int GAP     = 4;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_rw;
    logic [7*N_REQ-1:0] req_dev;
    logic [8*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_rdata;
    logic               rsp_err;
    logic               busy;
    logic               eng_send_en;
    logic               eng_recv_en;
    logic [6:0]         eng_dev;
    logic [7:0]         eng_addr;
    logic [7:0]         eng_wdata;
    logic               eng_done;
    logic [7:0]         eng_rdata;

    int checks;
    int failures;

    typedef struct {
        int         req;
        logic       rw;
        logic [6:0] dev;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] eng_rd;
        int         lat;
        bit         scramble;
        bit         drop;
        bit         hold;
        int         exp_winner;
        int         exp_en;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } txn_t;

    txn_t vecs[8];
    txn_t post0, post1, hang1, rr0, rr1;

    i2c_txn_arbiter #(
        .N_REQ  (N_REQ),
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_dev    (req_dev),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_send_en(eng_send_en),
        .eng_recv_en(eng_recv_en),
        .eng_dev    (eng_dev),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .eng_done   (eng_done),
        .eng_rdata  (eng_rdata)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Present one request on its requester's slot and raise its valid bit.
    task automatic applyStimulus(input txn_t v);
        req_rw[v.req]             = v.rw;
        req_dev[v.req*7 +: 7]     = v.dev;
        req_addr[v.req*8 +: 8]    = v.addr;
        req_wdata[v.req*8 +: 8]   = v.wdata;
        req_valid[v.req]          = 1'b1;
    endtask

    // Play the engine for one transaction, then check the response pulse
    // and the quiet gap that follows. v describes the expected winner.
    task automatic observeTransaction(input txn_t v, input string tag);
        int         en_cycles;
        int         first_en;
        int         wrong_en;
        int         bad_fld;
        int         not_busy;
        int         gap_busy;
        int         gap_bad;
        bit         seen;
        logic [N_REQ-1:0] rv;
        logic [7:0] rd;
        logic       er;
        en_cycles = 0;
        first_en  = -1;
        wrong_en  = 0;
        bad_fld   = 0;
        not_busy  = 0;
        seen      = 1'b0;
        rv        = '0;
        rd        = 8'h00;
        er        = 1'b0;
        eng_rdata = v.eng_rd;
        for (int c = 0; c < TIMEOUT + 40; c++) begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (|rsp_valid) begin
                seen = 1'b1;
                rv   = rsp_valid;
                rd   = rsp_rdata;
                er   = rsp_err;
                if (eng_send_en || eng_recv_en) wrong_en++;
                break;
            end
            if (eng_send_en || eng_recv_en) begin
                if (first_en < 0) first_en = c;
                en_cycles++;
                if (!busy) not_busy++;
                if (eng_send_en !== ~v.rw || eng_recv_en !== v.rw) wrong_en++;
                if (eng_dev !== v.dev || eng_addr !== v.addr || eng_wdata !== v.wdata)
                    bad_fld++;
                if (en_cycles == 2 && v.scramble) begin
                    req_dev[v.req*7 +: 7]   = ~v.dev;
                    req_addr[v.req*8 +: 8]  = ~v.addr;
                    req_wdata[v.req*8 +: 8] = ~v.wdata;
                    req_rw[v.req]           = ~v.rw;
                end
                if (en_cycles == 2 && v.drop) req_valid[v.req] = 1'b0;
                if (v.lat > 0 && en_cycles == v.lat + 1) eng_done = 1'b1;
            end
        end
        checkOutput({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_winner"}, 32'(rv), 32'(1 << v.exp_winner));
        checkOutput({tag, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
        checkOutput({tag, "_err"}, 32'(er), 32'(v.exp_err));
        checkOutput({tag, "_en_cycles"}, 32'(en_cycles), 32'(v.exp_en));
        checkOutput({tag, "_grant_latency"}, 32'(first_en), 32'd0);
        checkOutput({tag, "_wrong_enable"}, 32'(wrong_en), 32'd0);
        checkOutput({tag, "_eng_fields"}, 32'(bad_fld), 32'd0);
        checkOutput({tag, "_busy_in_txn"}, 32'(not_busy), 32'd0);
        if (!v.hold) req_valid[v.req] = 1'b0;

        // A stray eng_done during RESP/GAP_WAIT must not produce anything.
        eng_done = 1'b1;
        gap_busy = 0;
        gap_bad  = 0;
        for (int c = 0; c < GAP + 20; c++) begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (c == 0) begin
                checkOutput({tag, "_pulse_end"},
                            {22'd0, rsp_valid, rsp_rdata}, 32'd0);
                checkOutput({tag, "_err_end"}, 32'(rsp_err), 32'd0);
            end
            if (!busy) break;
            gap_busy++;
            if (eng_send_en || eng_recv_en || (|rsp_valid)) gap_bad++;
        end
        checkOutput({tag, "_gap_len"}, 32'(gap_busy), 32'(GAP));
        checkOutput({tag, "_gap_quiet"}, 32'(gap_bad), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_dev   = '0;
        req_addr  = '0;
        req_wdata = '0;
        eng_done  = 1'b0;
        eng_rdata = 8'h00;

        // req rw dev addr wdata eng_rd lat scr drop hold | win en rdata err
        vecs[0] = '{0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h3C, 300,     0, 0, 0, 0, 301, 8'h00, 1'b0};
        vecs[1] = '{1, 1'b1, 7'h68, 8'h75, 8'h00, 8'h71, 20,      0, 0, 0, 1, 21,  8'h71, 1'b0};
        vecs[2] = '{0, 1'b1, 7'h1A, 8'h02, 8'hFF, 8'hC3, 5,       1, 0, 0, 0, 6,   8'hC3, 1'b0};
        vecs[3] = '{1, 1'b0, 7'h22, 8'h33, 8'h44, 8'hEE, 0,       0, 0, 0, 1, 321, 8'h00, 1'b1};
        vecs[4] = '{1, 1'b1, 7'h2C, 8'h0F, 8'h00, 8'hEE, 0,       0, 1, 0, 1, 321, 8'h00, 1'b1};
        vecs[5] = '{0, 1'b1, 7'h3B, 8'h80, 8'h00, 8'h5A, 1,       0, 0, 0, 0, 2,   8'h5A, 1'b0};
        vecs[6] = '{1, 1'b1, 7'h45, 8'h46, 8'h00, 8'h99, TIMEOUT, 0, 0, 0, 1, 321, 8'h99, 1'b0};
        vecs[7] = '{0, 1'b0, 7'h7F, 8'hFF, 8'h81, 8'h12, 319,     0, 0, 0, 0, 320, 8'h00, 1'b0};

        hang1 = '{1, 1'b1, 7'h11, 8'h22, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 1'b0};
        post0 = '{0, 1'b0, 7'h0C, 8'h0D, 8'h0E, 8'h00, 3, 0, 0, 0, 0, 4, 8'h00, 1'b0};
        post1 = '{1, 1'b1, 7'h61, 8'h62, 8'h00, 8'hB7, 4, 0, 0, 0, 1, 5, 8'hB7, 1'b0};
        rr0   = '{0, 1'b0, 7'h30, 8'h31, 8'h32, 8'h00, 3, 0, 0, 1, 0, 4, 8'h00, 1'b0};
        rr1   = '{1, 1'b1, 7'h40, 8'h41, 8'h00, 8'h4D, 3, 0, 0, 1, 1, 4, 8'h4D, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp", {22'd0, rsp_valid, rsp_rdata}, 32'd0);
        checkOutput("reset_err_busy", {30'd0, rsp_err, busy}, 32'd0);
        checkOutput("reset_enables", {30'd0, eng_send_en, eng_recv_en}, 32'd0);
        checkOutput("reset_eng_fields", {9'd0, eng_dev, eng_addr, eng_wdata}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            observeTransaction(vecs[i], $sformatf("v%0d", i));
        end

        // eng_done while idle is ignored.
        eng_done = 1'b1;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_done_%0d", c), {30'd0, busy, |rsp_valid}, 32'd0);
        end

        // Reset 50 RUN cycles into a transaction for requester 1 while the
        // pointer favours requester 1; afterwards requester 0 must win.
        applyStimulus(hang1);
        for (int c = 0; c < 51; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_recv_en", 32'(eng_recv_en), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("reset_run_enables", {30'd0, eng_send_en, eng_recv_en}, 32'd0);
        checkOutput("reset_run_busy", 32'(busy), 32'd0);
        applyStimulus(post0);
        applyStimulus(post1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_run_rsp_%0d", c), 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        observeTransaction(post0, "post0");
        observeTransaction(post1, "post1");

        // Both requesters held high: strict alternation starting at 0.
        applyStimulus(rr0);
        applyStimulus(rr1);
        observeTransaction(rr0, "rr_a");
        observeTransaction(rr1, "rr_b");
        observeTransaction(rr0, "rr_c");
        observeTransaction(rr1, "rr_d");
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_idle", {30'd0, busy, |rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master engine between N_REQ requesters; each requester issues single-byte register writes or reads.
- Round-robin arbitration; latches the granted request and drives the engine's address/data inputs and its send or receive enable.
- Watches engine completion with a timeout, then returns read data and error status to the winning requester.
- Sits between system-side register clients (sensor pollers, config loaders) and the I2C engine.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT, 4096, max clk cycles the engine enable may stay high before abort
- GAP, 4, clk cycles both engine enables are held low between transactions (engine self-resets)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request pending, one bit per requester; held until rsp_valid
- req_rw  in  N_REQ  per requester: 0 = write, 1 = read
- req_dev  in  7*N_REQ  device address, requester i at [7i+6:7i]
- req_addr  in  8*N_REQ  register address, requester i at [8i+7:8i]
- req_wdata  in  8*N_REQ  write data, requester i at [8i+7:8i]
- rsp_valid  out  N_REQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  8  read byte; valid with rsp_valid
- rsp_err  out  1  timeout flag; valid with rsp_valid
- busy  out  1  high from grant until the end of GAP
- eng_send_en  out  1  engine write enable, held for the whole transaction
- eng_recv_en  out  1  engine read enable, held for the whole transaction
- eng_dev  out  7  device address to engine
- eng_addr  out  8  register address to engine
- eng_wdata  out  8  write data to engine
- eng_done  in  1  engine completion pulse
- eng_rdata  in  8  engine read byte; sampled in the cycle eng_done is high

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; round-robin pointer = 0; timeout counter = 0.
- States: IDLE, GRANT, RUN, RESP, GAP_WAIT.
- IDLE: if any req_valid bit is high, pick the first set bit searching from ptr upward, wrapping modulo N_REQ. Register the winner index and its rw/dev/addr/wdata. Go to GRANT. If no bit is set, stay in IDLE.
- GRANT (1 cycle):
  - Drive eng_dev/eng_addr/eng_wdata from the latched values.
  - Assert eng_send_en if the latched rw = 0, else eng_recv_en; never both.
  - Clear the counter; set busy. Go to RUN.
- RUN:
  - Hold the enable and all eng_* data stable; counter increments each cycle.
  - If eng_done = 1: capture eng_rdata (reads only; writes return 0x00); err = 0; go to RESP.
  - Else if counter = TIMEOUT-1: err = 1; rdata = 0x00; go to RESP.
  - If eng_done and the timeout coincide, eng_done wins (err = 0).
- RESP (1 cycle):
  - Drop both enables.
  - Pulse rsp_valid[winner] with rsp_rdata/rsp_err.
  - ptr = winner+1 (mod N_REQ). Go to GAP_WAIT.
- GAP_WAIT: enables stay low for GAP cycles, then busy = 0 and go to IDLE. A requester may re-raise req_valid immediately; it is considered on the next IDLE.
- Latency: grant-to-enable is 1 cycle after IDLE sampling. Minimum back-to-back spacing is 1 (IDLE) + 1 (GRANT) + engine time + 1 (RESP) + GAP cycles.
- rsp_rdata and rsp_err are 0 except during the rsp_valid cycle.
- A requester dropping req_valid while granted: the transaction still completes and the pulse is still issued (no abort).
- req_* changes after grant are ignored (latched copy used).
- eng_done outside RUN is ignored.
- Reset mid-RUN: enables drop asynchronously; no response is issued; ptr returns to 0.

Decomposition:
- Shared package i2c_arb_pkg: state encoding constants (IDLE..GAP_WAIT), RW_WRITE/RW_READ constants, default TIMEOUT/GAP.
- One sub-module: rr_pick (combinational round-robin first-set-bit search given ptr and req vector; outputs index + found).

Test Plan:
- Single write: N_REQ=2, req0 write dev=0x50 addr=0x10 wdata=0xA5; engine model pulses eng_done after 300 cycles -> eng_send_en high exactly 301 cycles (GRANT through last RUN cycle), eng_* = 0x50/0x10/0xA5, rsp_valid[0] one cycle, rsp_err=0, rsp_rdata=0x00.
- Single read: req1 read dev=0x68 addr=0x75; model returns 0x71 with eng_done -> eng_recv_en only, rsp_valid[1], rsp_rdata=0x71, rsp_err=0.
- Round-robin fairness: both req_valid held high continuously for 4 transactions -> grant order 0,1,0,1; at least GAP cycles of both enables low between transactions.
- Timeout: TIMEOUT=64, engine never pulses done -> enable drops after 64 RUN cycles, rsp_err=1, rsp_rdata=0x00; next request served normally.
- Coincident done and timeout at counter=TIMEOUT-1 -> rsp_err=0, data captured.
- Reset mid-RUN at cycle 50 -> enables 0 in the same cycle, no rsp_valid, first post-reset grant goes to requester 0.
